// File: rtl/pram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pram_pkg
// Description : Shared widths and requester-tag encoding for the PRAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package pram_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 64;
  localparam int WE_W   = 8;

  typedef enum logic {
    TAG_REQ1 = 1'b0,
    TAG_REQ2 = 1'b1
  } req_tag_e;

  typedef struct packed {
    logic     valid;
    req_tag_e tag;
  } rd_tag_t;

endpackage : pram_pkg
`default_nettype wire

// File: rtl/pram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : pram_port_arbiter_if
// Description : Requester and BRAM port-B signal bundle for the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface pram_port_arbiter_if;
  import pram_pkg::*;

  logic              req1;
  logic              req2;
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;
  logic [WE_W-1:0]   we1;
  logic [WE_W-1:0]   we2;
  logic [DATA_W-1:0] din1;
  logic [DATA_W-1:0] din2;
  logic              gnt1;
  logic              gnt2;
  logic              rvalid1;
  logic              rvalid2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic [ADDR_W-1:0] pRAM_addrB;
  logic [WE_W-1:0]   pRAM_weB;
  logic [DATA_W-1:0] pRAM_dinB;
  logic [DATA_W-1:0] pRAM_doutB;

  // Requesters plus the BRAM itself
  modport master (
    output req1, req2, addr1, addr2, we1, we2, din1, din2, pRAM_doutB,
    input  gnt1, gnt2, rvalid1, rvalid2, rdata1, rdata2,
    input  pRAM_addrB, pRAM_weB, pRAM_dinB
  );

  modport slave (
    input  req1, req2, addr1, addr2, we1, we2, din1, din2, pRAM_doutB,
    output gnt1, gnt2, rvalid1, rvalid2, rdata1, rdata2,
    output pRAM_addrB, pRAM_weB, pRAM_dinB
  );

endinterface : pram_port_arbiter_if
`default_nettype wire

// File: rtl/pram_rd_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : pram_rd_tag_pipe
// Description : Valid/requester-tag delay line tracking reads in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module pram_rd_tag_pipe
  import pram_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push_i,
  input  req_tag_e tag_i,
  output logic     valid_o,
  output req_tag_e tag_o
);

  rd_tag_t [DEPTH-1:0] stage_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= '{valid: push_i, tag: tag_i};
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign valid_o = stage_q[DEPTH-1].valid;
  assign tag_o   = stage_q[DEPTH-1].tag;

endmodule : pram_rd_tag_pipe
`default_nettype wire

// File: rtl/pram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pram_port_arbiter
// Description : Two-requester round-robin arbiter for BRAM port B with
//               tagged read-data return.
// Revision    : 1.0 - initial release
// ============================================================================
module pram_port_arbiter
  import pram_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic               trn_clk,
  input  logic               trn_reset,
  pram_port_arbiter_if.slave bus
);

  logic              gnt1_w;
  logic              gnt2_w;
  req_tag_e          prio_q, prio_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WE_W-1:0]   we_q, we_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              push_w;
  req_tag_e          push_tag_w;
  logic              pipe_valid_w;
  req_tag_e          pipe_tag_w;
  logic              rvalid1_q, rvalid1_d;
  logic              rvalid2_q, rvalid2_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [DATA_W-1:0] rdata2_q, rdata2_d;

  // prio_q names the requester that wins the next tie
  always_comb begin
    gnt1_w = 1'b0;
    gnt2_w = 1'b0;
    if (!trn_reset) begin
      if (bus.req1 && (!bus.req2 || prio_q == TAG_REQ1)) begin
        gnt1_w = 1'b1;
      end else if (bus.req2) begin
        gnt2_w = 1'b1;
      end
    end
  end

  always_comb begin
    prio_d     = prio_q;
    addr_d     = addr_q;
    we_d       = '0;
    din_d      = din_q;
    push_w     = 1'b0;
    push_tag_w = TAG_REQ1;
    if (gnt1_w) begin
      prio_d     = TAG_REQ2;
      addr_d     = bus.addr1;
      we_d       = bus.we1;
      din_d      = bus.din1;
      push_w     = (bus.we1 == '0);
      push_tag_w = TAG_REQ1;
    end else if (gnt2_w) begin
      prio_d     = TAG_REQ1;
      addr_d     = bus.addr2;
      we_d       = bus.we2;
      din_d      = bus.din2;
      push_w     = (bus.we2 == '0);
      push_tag_w = TAG_REQ2;
    end
    rvalid1_d = pipe_valid_w && (pipe_tag_w == TAG_REQ1);
    rvalid2_d = pipe_valid_w && (pipe_tag_w == TAG_REQ2);
    rdata1_d  = rvalid1_d ? bus.pRAM_doutB : rdata1_q;
    rdata2_d  = rvalid2_d ? bus.pRAM_doutB : rdata2_q;
  end

  always_ff @(posedge trn_clk) begin
    if (trn_reset) begin
      prio_q    <= TAG_REQ1;
      addr_q    <= '0;
      we_q      <= '0;
      din_q     <= '0;
      rvalid1_q <= 1'b0;
      rvalid2_q <= 1'b0;
      rdata1_q  <= '0;
      rdata2_q  <= '0;
    end else begin
      prio_q    <= prio_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      din_q     <= din_d;
      rvalid1_q <= rvalid1_d;
      rvalid2_q <= rvalid2_d;
      rdata1_q  <= rdata1_d;
      rdata2_q  <= rdata2_d;
    end
  end

  // One stage per cycle from grant until BRAM data is sampled
  pram_rd_tag_pipe #(
    .DEPTH (RD_LATENCY + 1)
  ) u_rd_tag_pipe (
    .clk     (trn_clk),
    .rst     (trn_reset),
    .push_i  (push_w),
    .tag_i   (push_tag_w),
    .valid_o (pipe_valid_w),
    .tag_o   (pipe_tag_w)
  );

  assign bus.gnt1       = gnt1_w;
  assign bus.gnt2       = gnt2_w;
  assign bus.rvalid1    = rvalid1_q;
  assign bus.rvalid2    = rvalid2_q;
  assign bus.rdata1     = rdata1_q;
  assign bus.rdata2     = rdata2_q;
  assign bus.pRAM_addrB = addr_q;
  assign bus.pRAM_weB   = we_q;
  assign bus.pRAM_dinB  = din_q;

endmodule : pram_port_arbiter
`default_nettype wire
